// File: rtl/mux_select_scanner_if.sv
// Handshake/bus bundle between the scan sequencer and its environment.
// The environment (master) drives control and mux_o; the scanner (slave) drives selects and status.
interface mux_select_scanner_if #(
  parameter int DWELL_W = 8,
  parameter int FRAME_W = 8
);
  logic               start;
  logic               stop;
  logic [3:0]         chan_en;
  logic [DWELL_W-1:0] dwell;
  logic               mux_o;
  logic               s1;
  logic               s0;
  logic               sel_valid;
  logic               busy;
  logic [3:0]         sample;
  logic               frame_done;
  logic [FRAME_W-1:0] frame_cnt;
  logic               err;

  modport master (
    output start, stop, chan_en, dwell, mux_o,
    input  s1, s0, sel_valid, busy, sample,
    input  frame_done, frame_cnt, err
  );

  modport slave (
    input  start, stop, chan_en, dwell, mux_o,
    output s1, s0, sel_valid, busy, sample,
    output frame_done, frame_cnt, err
  );
endinterface

// File: rtl/mux_select_scanner.sv
// Scans enabled 4:1 mux inputs in ascending order with a programmable dwell,
// capturing the mux output at the end of each channel window.
module mux_select_scanner #(
  parameter int DWELL_W = 8,
  parameter int FRAME_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_select_scanner_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  state_t             r_state;
  logic [1:0]         r_sel;
  logic               r_valid;
  logic               r_busy;
  logic [3:0]         r_mask;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_pend;
  logic [3:0]         r_sample;
  logic               r_fd;
  logic [FRAME_W-1:0] r_fcnt;
  logic               r_err;

  logic [DWELL_W-1:0] w_reload;
  logic [3:0]         w_hi;
  logic               w_wrap;
  logic [1:0]         w_nxt;
  logic [1:0]         w_first;
  logic               w_go;
  logic               w_halt;

  function automatic logic [1:0] lsb_idx(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (m[k]) idx = 2'(k);
    return idx;
  endfunction

  // window is max(dwell,1) cycles; counter runs reload..0
  assign w_reload = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
  assign w_hi     = r_mask & (4'b1110 << r_sel);
  assign w_wrap   = (w_hi == 4'b0000);
  assign w_nxt    = lsb_idx(w_hi);
  assign w_first  = lsb_idx(bus.chan_en);
  assign w_go     = bus.start && !bus.stop;
  assign w_halt   = (w_wrap && bus.chan_en == 4'b0000)
                    || r_pend || bus.stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel    <= 2'd0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_mask   <= 4'b0000;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_sample <= 4'b0000;
      r_fd     <= 1'b0;
      r_fcnt   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_fd  <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_go && bus.chan_en == 4'b0000) begin
            r_err <= 1'b1;
          end else if (w_go) begin
            r_mask  <= bus.chan_en;
            r_cnt   <= w_reload;
            r_sel   <= w_first;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_pend  <= 1'b0;
            r_state <= DWELL;
          end
        end
        DWELL: begin
          if (bus.stop) r_pend <= 1'b1;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_sample[r_sel] <= bus.mux_o;
            if (w_wrap) begin
              r_fd   <= 1'b1;
              r_fcnt <= r_fcnt + 1'b1;
              r_mask <= bus.chan_en;
            end
            // selects keep their last value when the scan halts
            if (w_halt) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_pend  <= 1'b0;
            end else begin
              r_cnt <= w_reload;
              r_sel <= w_wrap ? w_first : w_nxt;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s1         = r_sel[1];
  assign bus.s0         = r_sel[0];
  assign bus.sel_valid  = r_valid;
  assign bus.busy       = r_busy;
  assign bus.sample     = r_sample;
  assign bus.frame_done = r_fd;
  assign bus.frame_cnt  = r_fcnt;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_mux_select_scanner.sv
// Randomized and directed bench for mux_select_scanner against a
// channel-list reference model; a 4:1 mux is modelled around the DUT.
module tb_mux_select_scanner;

  localparam int DW = 8;
  localparam int FW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] r_in = 4'b0000;
  int         n_vec = 0;
  int         n_err = 0;

  mux_select_scanner_if #(.DWELL_W(DW), .FRAME_W(FW)) bus ();

  mux_select_scanner #(.DWELL_W(DW), .FRAME_W(FW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.mux_o = r_in[{bus.s1, bus.s0}];

  always #5 clk = ~clk;

  // reference model state
  bit       m_busy;
  int       m_sel;
  int       m_left;
  bit [3:0] m_mask;
  bit       m_pend;
  bit [3:0] m_sample;
  bit       m_fd;
  int       m_fcnt;
  bit       m_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_of(input bit [3:0] m, input int from);
    for (int k = from; k < 4; k++)
      if (m[k]) return k;
    return -1;
  endfunction

  function automatic int window(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_left = 0; m_mask = 0; m_pend = 0;
    m_sample = 0; m_fd = 0; m_fcnt = 0; m_err = 0;
  endtask

  task automatic model_step(input bit st, input bit sp,
                            input bit [3:0] ce, input int dw);
    int nxt;
    m_fd  = 0;
    m_err = 0;
    if (!m_busy) begin
      if (st && !sp) begin
        if (ce == 0) m_err = 1;
        else begin
          m_mask = ce;
          m_sel  = first_of(ce, 0);
          m_left = window(dw);
          m_busy = 1;
          m_pend = 0;
        end
      end
    end else begin
      m_pend = m_pend | sp;
      if (m_left > 1) m_left--;
      else begin
        m_sample[m_sel] = r_in[m_sel];
        nxt = first_of(m_mask, m_sel + 1);
        if (nxt < 0) begin
          m_fd   = 1;
          m_fcnt = (m_fcnt + 1) % (1 << FW);
          m_mask = ce;
        end
        if ((nxt < 0 && m_mask == 0) || m_pend) begin
          m_busy = 0;
          m_pend = 0;
        end else begin
          m_left = window(dw);
          m_sel  = (nxt < 0) ? first_of(m_mask, 0) : nxt;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("sel",        {bus.s1, bus.s0}, m_sel);
    chk("sel_valid",  bus.sel_valid,    m_busy);
    chk("busy",       bus.busy,         m_busy);
    chk("sample",     bus.sample,       m_sample);
    chk("frame_done", bus.frame_done,   m_fd);
    chk("frame_cnt",  bus.frame_cnt,    m_fcnt);
    chk("err",        bus.err,          m_err);
  endtask

  task automatic cyc(input bit st, input bit sp, input bit [3:0] ce,
                     input int dw, input bit [3:0] din);
    bus.start   = st;
    bus.stop    = sp;
    bus.chan_en = ce;
    bus.dwell   = DW'(dw);
    r_in        = din;
    model_step(st, sp, ce, dw);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic scenario1();
    cyc(1, 0, 4'b1111, 2, 4'b1010);
    for (int i = 0; i < 8; i++) cyc(0, 0, 4'b1111, 2, 4'b1010);
    chk("s1_sample", bus.sample, 4'b1010);
    chk("s1_fdone",  bus.frame_done, 1'b1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 4'b1111, 2, 4'b1010);
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.chan_en = 0; bus.dwell = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    scenario1();

    cyc(1, 0, 4'b0101, 0, 4'b1111);
    for (int i = 0; i < 8; i++) cyc(0, 0, 4'b0101, 0, 4'($urandom));
    for (int i = 0; i < 3; i++) cyc(0, 1, 4'b0101, 0, 4'b1111);

    cyc(1, 0, 4'b0000, 2, 4'b0000);
    cyc(0, 0, 4'b0000, 2, 4'b0000);
    cyc(1, 1, 4'b1111, 2, 4'b0000);
    cyc(0, 0, 4'b1111, 2, 4'b0000);

    cyc(1, 0, 4'b1111, 3, 4'b0110);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'b1111, 3, 4'b0110);
    cyc(0, 1, 4'b1111, 3, 4'b0110);
    for (int i = 0; i < 4; i++) cyc(0, 0, 4'b1111, 3, 4'b0110);

    cyc(1, 0, 4'b1000, 1, 4'b1000);
    for (int i = 0; i < 6; i++) cyc(0, 0, 4'b1000, 1, 4'b1000);
    cyc(0, 1, 4'b1000, 1, 4'b1000);
    cyc(0, 0, 4'b1000, 1, 4'b1000);

    cyc(1, 0, 4'b1111, 3, 4'b1111);
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'b1111, 3, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sel",   {bus.s1, bus.s0}, 2'b00);
    chk("rst_busy",  {bus.busy, bus.sel_valid}, 2'b00);
    chk("rst_smp",   bus.sample, 4'b0000);
    chk("rst_fcnt",  bus.frame_cnt, 2'b00);
    chk("rst_pulse", {bus.frame_done, bus.err}, 2'b00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    scenario1();

    for (int i = 0; i < 2000; i++) begin
      bit [3:0] ce;
      ce = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
          ce, $urandom_range(0, 3), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
